datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
Multicycle control FSM for the 8-bit datapath. It sequences fetch, decode, execute and write-back by driving every datapath control strobe from its current state, the opcode field IR[3:0] and the N/Z flags. It sits beside the datapath in the processor top level. It also provides run/halt control for the board.

Parameters:
MEM_RD_LAT, 1, cycles from MemRead assertion to valid Data_out; legal range 1..4.

Ports:
CLOCK_50 in 1 system clock
RESET_N in 1 asynchronous active-low reset
run in 1 allow instruction issue
OpCode in 8 instruction register contents (IR[7:6]=Rx, IR[5:4]=Ry, IR[3:0]=op)
N, Z in 1 each ALU flags from the flag register
PCwrite, AddrSel, MemRead, MemWrite, IRload, MDRload, RASel, RFWrite, RegIn, ABLD, ALU_A, FlagWrite, ALUoutLD out 1 each datapath strobes/selects
ALU_B out 3 B-mux select: 000 Ry, 001 const 1, 010 sext IR[7:4], 011 zext IR[7:3], 100 IR[7:6]
ALUop out 3 ADD 000, SUB 001, NAND 010, OR 011, SHL 100, SHR 101
halted out 1 STOP executed
state_dbg out 4 current state encoding, for LEDs

Behaviour:
- Opcodes:
  - LOAD 0000, STORE 0010, ADD 0100, SUB 0110, NAND 1000.
  - ORI x111: R1 |= zext IR[7:3].
  - SHR 0011 and SHL 1011: shift R1 by IR[7:6].
  - BZ 0101, BNZ 1001, BPZ 1101.
  - STOP 0001.
  - 1010, 1100 and 1110 are NOP.
- Outputs are Moore-style, decoded from the state register and OpCode. The only exception is PCwrite in BR, which also depends on N and Z. Any strobe not listed for a state is 0; RegIn=0 means the ALU result feeds dataW and RegIn=1 means MDR feeds dataW.
- Reset (asynchronous, RESET_N=0): state goes to IDLE, the wait counter clears, all outputs are 0 immediately and halted=0. A reset mid-instruction aborts the instruction, including dropping MemWrite in the same cycle.
- IDLE: stays while run=0; moves to FETCH when run=1.
- FETCH: AddrSel=1, MemRead=1. Held for MEM_RD_LAT cycles using a 2-bit wait counter, then goes to IRLD.
- IRLD: AddrSel=1, IRload=1, ALU_A=0, ALU_B=001, ALUop=ADD, PCwrite=1, so PC becomes PC+1. Goes to DECODE.
- DECODE: ABLD=1; RASel=1 for ORI, SHL and SHR.
  - Next state: LOAD to MRD, STORE to ST, ADD/SUB/NAND/ORI/SHx to EX, branches to BR, STOP to HALT.
  - NOP goes to the boundary check.
- MRD: AddrSel=0, MemRead=1 for MEM_RD_LAT cycles, then LDM.
- LDM: MDRload=1, then LWB.
- LWB: RegIn=1, RFWrite=1, RASel=0, then the boundary check.
- ST: AddrSel=0, MemWrite=1 for exactly 1 cycle, then the boundary check.
- EX: ALU_A=1, FlagWrite=1, ALUoutLD=1, then WB.
  - ALU_B=000 for ADD/SUB/NAND, 011 for ORI, 100 for SHx.
  - ALUop per opcode.
  - RASel held as in DECODE.
- WB: RFWrite=1, RegIn=0, RASel as in EX, then the boundary check.
- BR: taken when (BZ and Z=1), (BNZ and Z=0) or (BPZ and N=0). If taken: ALU_A=0, ALU_B=010, ALUop=ADD, PCwrite=1, so the offset is relative to the already-incremented PC. If not taken, no strobes. Then the boundary check.
- Boundary check: go to FETCH if run=1, otherwise IDLE. Deasserting run mid-instruction lets the instruction complete.
- HALT: halted=1 and all strobes 0. Exited only by reset; run is ignored.
- Cycle counts with L=MEM_RD_LAT:
  - ALU/ORI/SHx: L+4.
  - LOAD: 2L+4.
  - STORE, branch: L+3.
  - NOP: L+2.
- PCwrite is never asserted in two consecutive cycles. MemRead and MemWrite are never asserted together.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encodings (4-bit);
  - opcode constants;
  - ALUop codes;
  - ALU_B select codes;
  - the MEM_RD_LAT legal range.
- One natural sub-module, ctrl_opdecode: combinational OpCode[3:0] to one-hot instruction class (ld, st, alu_rr, ori, shl, shr, br, stop, nop) plus the ALUop value.

Test Plan:
- Hold RESET_N=0 with run=1, then release → IDLE for the reset cycle, FETCH next. Pulling RESET_N low mid-ST forces MemWrite=0 in the same cycle and state_dbg=IDLE.
- ADD, OpCode=0x14, L=1 → exact strobe sequence FETCH/IRLD/DECODE/EX/WB over 5 cycles. EX has ALU_B=000, ALUop=000, FlagWrite=1; WB has RFWrite=1, RegIn=0.
- LOAD, OpCode=0x40, L=2 → MemRead high 2 cycles with AddrSel=0, then MDRload for 1 cycle, then RFWrite with RegIn=1. Total 8 cycles.
- BZ, OpCode=0xE5 (offset -2): with Z=1, PCwrite=1, ALU_B=010, ALU_A=0 in BR. With Z=0, PCwrite=0 in BR. Repeat for BNZ and BPZ over all N/Z combinations.
- ORI, OpCode=0xF7 → RASel=1 in DECODE, EX and WB; ALU_B=011; ALUop=011. SHL, OpCode=0x8B → ALU_B=100, ALUop=100.
- STOP, OpCode=0x01 → HALT after DECODE with halted=1; run toggling is ignored. Dropping run during EX → WB completes, then IDLE, no FETCH.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multicycle control unit of the 8-bit datapath:
//   - 4-bit FSM state encodings (also shown on the board LEDs via state_dbg)
//   - opcode constants for IR[3:0]
//   - ALU operation codes and ALU B-mux select codes
//   - decoded instruction class record handed from ctrl_opdecode to the FSM
//   - legal memory read latency range and a helper to clamp to it
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Memory read latency, in cycles from MemRead assertion to valid Data_out.
  // The FSM wait counter is 2 bits wide, which caps the latency at 4.
  localparam int unsigned MEM_RD_LAT_MIN = 1;
  localparam int unsigned MEM_RD_LAT_MAX = 4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_IRLD   = 4'd2,
    S_DECODE = 4'd3,
    S_MRD    = 4'd4,
    S_LDM    = 4'd5,
    S_LWB    = 4'd6,
    S_ST     = 4'd7,
    S_EX     = 4'd8,
    S_WB     = 4'd9,
    S_BR     = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  // Opcode field IR[3:0]. ORI is matched on the low three bits only (x111).
  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_STOP   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_SHR    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_BZ     = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_NAND   = 4'b1000;
  localparam logic [3:0] OP_BNZ    = 4'b1001;
  localparam logic [3:0] OP_SHL    = 4'b1011;
  localparam logic [3:0] OP_BPZ    = 4'b1101;
  localparam logic [2:0] OP_ORI_LO = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_NAND = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SHL  = 3'b100,
    ALU_SHR  = 3'b101
  } aluop_e;

  typedef enum logic [2:0] {
    ALUB_RY    = 3'b000,  // register Ry
    ALUB_ONE   = 3'b001,  // constant 1 (PC increment)
    ALUB_SEXT  = 3'b010,  // sign-extended IR[7:4] (branch offset)
    ALUB_ZEXT  = 3'b011,  // zero-extended IR[7:3] (ORI immediate)
    ALUB_SHAMT = 3'b100   // IR[7:6] (shift amount)
  } alub_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_Z    = 2'd1,
    BR_NZ   = 2'd2,
    BR_PZ   = 2'd3
  } br_kind_e;

  // One-hot instruction class plus the ALU operation the class needs in EX.
  typedef struct packed {
    logic     ld;
    logic     st;
    logic     alu_rr;
    logic     ori;
    logic     shl;
    logic     shr;
    logic     br;
    logic     stop;
    logic     nop;
    br_kind_e br_kind;
    aluop_e   aluop;
  } instr_t;

  // Out-of-range latencies are pulled back into the range the counter covers.
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < MEM_RD_LAT_MIN) return MEM_RD_LAT_MIN;
    if (lat > MEM_RD_LAT_MAX) return MEM_RD_LAT_MAX;
    return lat;
  endfunction

endpackage : cpu_ctrl_pkg

// File: rtl/ctrl_opdecode.sv
// -----------------------------------------------------------------------------
// ctrl_opdecode
// Purely combinational decode of the opcode field IR[3:0] into a one-hot
// instruction class, the branch condition kind and the ALU operation.
// Ports:
//   op_i    [3:0]  opcode field IR[3:0]
//   instr_o        decoded class record (instr_t)
// -----------------------------------------------------------------------------
module ctrl_opdecode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output instr_t     instr_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    instr_o         = '0;
    instr_o.br_kind = BR_NONE;
    instr_o.aluop   = ALU_ADD;

    // ORI occupies both 0111 and 1111, so it is matched ahead of the case.
    if (op_i[2:0] == OP_ORI_LO) begin
      instr_o.ori   = 1'b1;
      instr_o.aluop = ALU_OR;
    end else begin
      case (op_i)
        OP_LOAD:  instr_o.ld = 1'b1;
        OP_STORE: instr_o.st = 1'b1;
        OP_ADD: begin
          instr_o.alu_rr = 1'b1;
          instr_o.aluop  = ALU_ADD;
        end
        OP_SUB: begin
          instr_o.alu_rr = 1'b1;
          instr_o.aluop  = ALU_SUB;
        end
        OP_NAND: begin
          instr_o.alu_rr = 1'b1;
          instr_o.aluop  = ALU_NAND;
        end
        OP_SHL: begin
          instr_o.shl   = 1'b1;
          instr_o.aluop = ALU_SHL;
        end
        OP_SHR: begin
          instr_o.shr   = 1'b1;
          instr_o.aluop = ALU_SHR;
        end
        OP_BZ: begin
          instr_o.br      = 1'b1;
          instr_o.br_kind = BR_Z;
        end
        OP_BNZ: begin
          instr_o.br      = 1'b1;
          instr_o.br_kind = BR_NZ;
        end
        OP_BPZ: begin
          instr_o.br      = 1'b1;
          instr_o.br_kind = BR_PZ;
        end
        OP_STOP: instr_o.stop = 1'b1;
        // Remaining codes 1010, 1100 and 1110 are NOPs.
        default: instr_o.nop = 1'b1;
      endcase
    end
  end

endmodule : ctrl_opdecode

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Multicycle control FSM for the 8-bit datapath. Sequences fetch, decode,
// execute and write-back, and provides run/halt control for the board.
// Parameters:
//   MEM_RD_LAT   cycles from MemRead to valid memory data (1..4)
// Ports:
//   CLOCK_50     system clock
//   RESET_N      asynchronous active-low reset
//   run          allow instruction issue at instruction boundaries
//   OpCode[7:0]  instruction register (IR[3:0] is the opcode)
//   N, Z         ALU flags from the flag register
//   PCwrite .. ALUoutLD   single-bit datapath strobes/selects
//   ALU_B[2:0]   ALU B-mux select
//   ALUop[2:0]   ALU operation
//   halted       high while in HALT (STOP executed)
//   state_dbg    current state encoding for the LEDs
// -----------------------------------------------------------------------------
module datapath_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       run,
  input  logic [7:0] OpCode,
  input  logic       N,
  input  logic       Z,
  output logic       PCwrite,
  output logic       AddrSel,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRload,
  output logic       MDRload,
  output logic       RASel,
  output logic       RFWrite,
  output logic       RegIn,
  output logic       ABLD,
  output logic       ALU_A,
  output logic       FlagWrite,
  output logic       ALUoutLD,
  output logic [2:0] ALU_B,
  output logic [2:0] ALUop,
  output logic       halted,
  output logic [3:0] state_dbg
);

  localparam int unsigned LAT       = clamp_lat(MEM_RD_LAT);
  // Memory-wait states exit when the counter reaches LAT-1.
  localparam logic [1:0]  WAIT_LAST = 2'(LAT - 1);

  state_e     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  instr_t     instr;
  logic       r_class;      // instruction operates on R1 (RASel=1)
  logic       br_taken;
  state_e     after_instr;  // instruction-boundary target

  // Only the opcode nibble drives control; the register fields feed the
  // datapath directly.
  logic [3:0] unused_opcode_hi;
  assign unused_opcode_hi = OpCode[7:4];

  ctrl_opdecode u_opdecode (
    .op_i    (OpCode[3:0]),
    .instr_o (instr)
  );

  assign r_class     = instr.ori | instr.shl | instr.shr;
  assign br_taken    = ((instr.br_kind == BR_Z)  &&  Z) ||
                       ((instr.br_kind == BR_NZ) && !Z) ||
                       ((instr.br_kind == BR_PZ) && !N);
  assign after_instr = run ? S_FETCH : S_IDLE;

  // ---------------------------------------------------------------------------
  // State and wait-counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_IRLD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_IRLD: state_d = S_DECODE;

      S_DECODE: begin
        if (instr.ld)                                   state_d = S_MRD;
        else if (instr.st)                              state_d = S_ST;
        else if (instr.alu_rr || r_class)               state_d = S_EX;
        else if (instr.br)                              state_d = S_BR;
        else if (instr.stop)                            state_d = S_HALT;
        else                                            state_d = after_instr;
      end

      S_MRD: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_LDM;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_LDM: state_d = S_LWB;
      S_LWB: state_d = after_instr;
      S_ST:  state_d = after_instr;
      S_EX:  state_d = S_WB;
      S_WB:  state_d = after_instr;
      S_BR:  state_d = after_instr;

      // Only reset leaves HALT; run is deliberately ignored here.
      S_HALT: state_d = S_HALT;

      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, except PCwrite in BR which follows N/Z)
  // ---------------------------------------------------------------------------
  always_comb begin
    PCwrite   = 1'b0;
    AddrSel   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRload    = 1'b0;
    MDRload   = 1'b0;
    RASel     = 1'b0;
    RFWrite   = 1'b0;
    RegIn     = 1'b0;
    ABLD      = 1'b0;
    ALU_A     = 1'b0;
    FlagWrite = 1'b0;
    ALUoutLD  = 1'b0;
    ALU_B     = ALUB_RY;
    ALUop     = ALU_ADD;
    halted    = 1'b0;
    state_dbg = state_q;

    case (state_q)
      S_FETCH: begin
        AddrSel = 1'b1;
        MemRead = 1'b1;
      end

      // PC <= PC + 1 while the instruction register captures memory data.
      S_IRLD: begin
        AddrSel = 1'b1;
        IRload  = 1'b1;
        ALU_A   = 1'b0;
        ALU_B   = ALUB_ONE;
        ALUop   = ALU_ADD;
        PCwrite = 1'b1;
      end

      S_DECODE: begin
        ABLD  = 1'b1;
        RASel = r_class;
      end

      S_MRD: begin
        AddrSel = 1'b0;
        MemRead = 1'b1;
      end

      S_LDM: MDRload = 1'b1;

      S_LWB: begin
        RegIn   = 1'b1;
        RFWrite = 1'b1;
        RASel   = 1'b0;
      end

      S_ST: begin
        AddrSel  = 1'b0;
        MemWrite = 1'b1;
      end

      S_EX: begin
        ALU_A     = 1'b1;
        FlagWrite = 1'b1;
        ALUoutLD  = 1'b1;
        RASel     = r_class;
        ALUop     = instr.aluop;
        if (instr.ori)                  ALU_B = ALUB_ZEXT;
        else if (instr.shl || instr.shr) ALU_B = ALUB_SHAMT;
        else                            ALU_B = ALUB_RY;
      end

      S_WB: begin
        RFWrite = 1'b1;
        RegIn   = 1'b0;
        RASel   = r_class;
      end

      // Offset is added to the PC that IRLD already incremented.
      S_BR: begin
        if (br_taken) begin
          ALU_A   = 1'b0;
          ALU_B   = ALUB_SEXT;
          ALUop   = ALU_ADD;
          PCwrite = 1'b1;
        end
      end

      S_HALT: halted = 1'b1;

      default: ;
    endcase
  end

endmodule : datapath_ctrl

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
// Directed bench for datapath_ctrl. Two instances share clock and inputs:
// index 0 has MEM_RD_LAT=1, index 1 has MEM_RD_LAT=2. Each cycle the outputs
// of the instance under test are packed into a 24-bit vector and compared
// with a hand-built expected vector.
// Vector layout:
//   [23] PCwrite [22] AddrSel [21] MemRead [20] MemWrite [19] IRload
//   [18] MDRload [17] RASel [16] RFWrite [15] RegIn [14] ABLD [13] ALU_A
//   [12] FlagWrite [11] ALUoutLD [10:8] ALU_B [7:5] ALUop [4] halted
//   [3:0] state_dbg
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

  localparam logic [23:0] PCW  = 24'h800000;
  localparam logic [23:0] ASEL = 24'h400000;
  localparam logic [23:0] MRD  = 24'h200000;
  localparam logic [23:0] MWR  = 24'h100000;
  localparam logic [23:0] IRL  = 24'h080000;
  localparam logic [23:0] MDRL = 24'h040000;
  localparam logic [23:0] RAS  = 24'h020000;
  localparam logic [23:0] RFW  = 24'h010000;
  localparam logic [23:0] RGI  = 24'h008000;
  localparam logic [23:0] ABL  = 24'h004000;
  localparam logic [23:0] ALA  = 24'h002000;
  localparam logic [23:0] FLW  = 24'h001000;
  localparam logic [23:0] AOL  = 24'h000800;
  localparam logic [23:0] HLT  = 24'h000010;

  // State encodings as shown on state_dbg.
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_IRLD = 2, ST_DECODE = 3;
  localparam int ST_MRD = 4, ST_LDM = 5, ST_LWB = 6, ST_ST = 7;
  localparam int ST_EX = 8, ST_WB = 9, ST_BR = 10, ST_HALT = 11;

  function automatic logic [23:0] bsel(input int x);
    return 24'(x) << 8;
  endfunction

  function automatic logic [23:0] aop(input int x);
    return 24'(x) << 5;
  endfunction

  function automatic logic [23:0] st(input int x);
    return 24'(x);
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b1;
  logic [7:0] OpCode = 8'h00;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic [23:0] vec [2];

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pcw, asel, mrd, mwr, irl, mdrl, ras, rfw, rgi, abl, ala, flw, aol, hlt;
    logic [2:0] alub, aluop;
    logic [3:0] sdbg;

    datapath_ctrl #(.MEM_RD_LAT(g + 1)) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .run       (run),
      .OpCode    (OpCode),
      .N         (N),
      .Z         (Z),
      .PCwrite   (pcw),
      .AddrSel   (asel),
      .MemRead   (mrd),
      .MemWrite  (mwr),
      .IRload    (irl),
      .MDRload   (mdrl),
      .RASel     (ras),
      .RFWrite   (rfw),
      .RegIn     (rgi),
      .ABLD      (abl),
      .ALU_A     (ala),
      .FlagWrite (flw),
      .ALUoutLD  (aol),
      .ALU_B     (alub),
      .ALUop     (aluop),
      .halted    (hlt),
      .state_dbg (sdbg)
    );

    assign vec[g] = {pcw, asel, mrd, mwr, irl, mdrl, ras, rfw, rgi, abl, ala,
                     flw, aol, alub, aluop, hlt, sdbg};
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic        run;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [23:0] got,
                       input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample.
  task automatic step(input int sel, input string name, input logic [7:0] op,
                      input logic n_v, input logic z_v, input logic run_v,
                      input logic [23:0] exp);
    @(negedge clk);
    OpCode = op;
    N      = n_v;
    Z      = z_v;
    run    = run_v;
    #1;
    check(name, vec[sel], exp);
  endtask

  // Reset both instances for one cycle with run=1 and check the reset cycle.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b1;
    N     = 1'b0;
    Z     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(name, vec[0], st(ST_IDLE));
  endtask

  task automatic add(input string name, input logic [7:0] op,
                     input logic r, input logic [23:0] exp);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.run  = r;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  localparam logic [23:0] F  = ASEL | MRD | 24'(ST_FETCH);
  localparam logic [23:0] I  = ASEL | IRL | PCW | (24'd1 << 8) | 24'(ST_IRLD);
  localparam logic [23:0] D  = ABL | 24'(ST_DECODE);
  localparam logic [23:0] DR = ABL | RAS | 24'(ST_DECODE);
  localparam logic [23:0] EXB = ALA | FLW | AOL | 24'(ST_EX);

  initial begin
    // Instruction stream for the MEM_RD_LAT=1 instance, run held high except
    // where noted.
    add("add_fetch", 8'h14, 1, F);
    add("add_irld",  8'h14, 1, I);
    add("add_dec",   8'h14, 1, D);
    add("add_ex",    8'h14, 1, EXB | bsel(0) | aop(0));
    add("add_wb",    8'h14, 1, RFW | st(ST_WB));
    add("ori_fetch", 8'hF7, 1, F);
    add("ori_irld",  8'hF7, 1, I);
    add("ori_dec",   8'hF7, 1, DR);
    add("ori_ex",    8'hF7, 1, EXB | RAS | bsel(3) | aop(3));
    add("ori_wb",    8'hF7, 1, RFW | RAS | st(ST_WB));
    add("shl_fetch", 8'h8B, 1, F);
    add("shl_irld",  8'h8B, 1, I);
    add("shl_dec",   8'h8B, 1, DR);
    add("shl_ex",    8'h8B, 1, EXB | RAS | bsel(4) | aop(4));
    add("shl_wb",    8'h8B, 1, RFW | RAS | st(ST_WB));
    add("shr_fetch", 8'h43, 1, F);
    add("shr_irld",  8'h43, 1, I);
    add("shr_dec",   8'h43, 1, DR);
    add("shr_ex",    8'h43, 1, EXB | RAS | bsel(4) | aop(5));
    add("shr_wb",    8'h43, 1, RFW | RAS | st(ST_WB));
    add("sub_fetch", 8'h26, 1, F);
    add("sub_irld",  8'h26, 1, I);
    add("sub_dec",   8'h26, 1, D);
    add("sub_ex",    8'h26, 1, EXB | bsel(0) | aop(1));
    add("sub_wb",    8'h26, 1, RFW | st(ST_WB));
    add("nand_fetch", 8'h18, 1, F);
    add("nand_irld", 8'h18, 1, I);
    add("nand_dec",  8'h18, 1, D);
    add("nand_ex",   8'h18, 1, EXB | bsel(0) | aop(2));
    add("nand_wb",   8'h18, 1, RFW | st(ST_WB));
    add("ld_fetch",  8'h40, 1, F);
    add("ld_irld",   8'h40, 1, I);
    add("ld_dec",    8'h40, 1, D);
    add("ld_mrd",    8'h40, 1, MRD | st(ST_MRD));
    add("ld_ldm",    8'h40, 1, MDRL | st(ST_LDM));
    add("ld_lwb",    8'h40, 1, RGI | RFW | st(ST_LWB));
    add("st_fetch",  8'h52, 1, F);
    add("st_irld",   8'h52, 1, I);
    add("st_dec",    8'h52, 1, D);
    add("st_st",     8'h52, 1, MWR | st(ST_ST));
    add("nop_fetch", 8'h0A, 1, F);
    add("nop_irld",  8'h0A, 1, I);
    add("nop_dec",   8'h0A, 1, D);
    add("nop2_fetch", 8'h3E, 1, F);
    add("nop2_irld", 8'h3E, 1, I);
    add("nop2_dec",  8'h3E, 1, D);
    // run dropped during EX: WB still completes, then IDLE without FETCH.
    add("drop_fetch", 8'h14, 1, F);
    add("drop_irld", 8'h14, 1, I);
    add("drop_dec",  8'h14, 1, D);
    add("drop_ex",   8'h14, 0, EXB | bsel(0) | aop(0));
    add("drop_wb",   8'h14, 0, RFW | st(ST_WB));
    add("drop_idle", 8'h14, 0, st(ST_IDLE));
    add("drop_idle2", 8'h14, 1, st(ST_IDLE));
    // STOP: HALT regardless of run.
    add("stop_fetch", 8'h01, 1, F);
    add("stop_irld", 8'h01, 1, I);
    add("stop_dec",  8'h01, 1, D);
    add("halt_run1", 8'h01, 1, HLT | st(ST_HALT));
    add("halt_run0", 8'h01, 0, HLT | st(ST_HALT));
    add("halt_run1b", 8'h01, 1, HLT | st(ST_HALT));

    // Reset held with run=1: everything zero, state IDLE.
    repeat (3) @(negedge clk);
    #1;
    check("reset_a", vec[0], 24'h0);
    check("reset_b", vec[1], 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_idle", vec[0], st(ST_IDLE));

    foreach (tbl[i]) step(0, tbl[i].name, tbl[i].op, 1'b0, 1'b0, tbl[i].run, tbl[i].exp);

    // Branches over every N/Z combination.
    do_reset("reset_br");
    for (int k = 0; k < 3; k++) begin
      logic [7:0] bop;
      bop = (k == 0) ? 8'hE5 : (k == 1) ? 8'hE9 : 8'hED;
      for (int nz = 0; nz < 4; nz++) begin
        logic nv, zv, taken;
        string tag;
        nv    = nz[1];
        zv    = nz[0];
        taken = (k == 0) ? zv : (k == 1) ? !zv : !nv;
        tag   = $sformatf("br%0d_n%0d_z%0d", k, nv, zv);
        step(0, {tag, "_fetch"}, bop, nv, zv, 1'b1, F);
        step(0, {tag, "_irld"},  bop, nv, zv, 1'b1, I);
        step(0, {tag, "_dec"},   bop, nv, zv, 1'b1, D);
        step(0, {tag, "_br"},    bop, nv, zv, 1'b1,
             taken ? (PCW | bsel(2) | st(ST_BR)) : st(ST_BR));
      end
    end

    // Reset during ST drops MemWrite in the same cycle.
    step(0, "abort_fetch", 8'h52, 1'b0, 1'b0, 1'b1, F);
    step(0, "abort_irld",  8'h52, 1'b0, 1'b0, 1'b1, I);
    step(0, "abort_dec",   8'h52, 1'b0, 1'b0, 1'b1, D);
    step(0, "abort_st",    8'h52, 1'b0, 1'b0, 1'b1, MWR | st(ST_ST));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_reset", vec[0], 24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // MEM_RD_LAT=2: LOAD takes 8 cycles, ADD takes 6.
    do_reset("reset_l2");
    step(1, "l2_ld_fetch1", 8'h40, 1'b0, 1'b0, 1'b1, F);
    step(1, "l2_ld_fetch2", 8'h40, 1'b0, 1'b0, 1'b1, F);
    step(1, "l2_ld_irld",   8'h40, 1'b0, 1'b0, 1'b1, I);
    step(1, "l2_ld_dec",    8'h40, 1'b0, 1'b0, 1'b1, D);
    step(1, "l2_ld_mrd1",   8'h40, 1'b0, 1'b0, 1'b1, MRD | st(ST_MRD));
    step(1, "l2_ld_mrd2",   8'h40, 1'b0, 1'b0, 1'b1, MRD | st(ST_MRD));
    step(1, "l2_ld_ldm",    8'h40, 1'b0, 1'b0, 1'b1, MDRL | st(ST_LDM));
    step(1, "l2_ld_lwb",    8'h40, 1'b0, 1'b0, 1'b1, RGI | RFW | st(ST_LWB));
    step(1, "l2_add_fetch1", 8'h14, 1'b0, 1'b0, 1'b1, F);
    step(1, "l2_add_fetch2", 8'h14, 1'b0, 1'b0, 1'b1, F);
    step(1, "l2_add_irld",  8'h14, 1'b0, 1'b0, 1'b1, I);
    step(1, "l2_add_dec",   8'h14, 1'b0, 1'b0, 1'b1, D);
    step(1, "l2_add_ex",    8'h14, 1'b0, 1'b0, 1'b1, EXB | bsel(0) | aop(0));
    step(1, "l2_add_wb",    8'h14, 1'b0, 1'b0, 0,    RFW | st(ST_WB));
    step(1, "l2_idle",      8'h14, 1'b0, 1'b0, 0,    st(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_datapath_ctrl
